// File: rtl/avmm_req_master_if.sv
`default_nettype none
// =====================================================================
// Module   : avmm_req_master_if
// Purpose  : Avalon-MM master/slave bundle used by avmm_req_master.
// Revision : 1.0 - initial release
// =====================================================================
interface avmm_req_master_if #(
    parameter int ADDR_W = 32,
    parameter int BCW    = 11
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [BCW-1:0]    burstcount;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/avmm_req_master.sv
`default_nettype none
// =====================================================================
// Module   : avmm_req_master
// Purpose  : Avalon-MM master executing bridge FIFO requests; echoes
//            headers and returns read data on the response stream.
//            Optional watchdog: define AVMM_REQ_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// =====================================================================
module avmm_req_master #(
    parameter int  MAX_BURST   = 1024,
    parameter int  ADDR_W      = 32,
    parameter int  TIMEOUT_CYC = 4096,
    localparam int BCW         = $clog2(MAX_BURST) + 1
) (
    input  wire logic           clk_i,
    input  wire logic           rstn_i,
    output logic                req_rdreq_o,
    input  wire logic [31:0]    req_q_i,
    input  wire logic           req_rdempty_i,
    input  wire logic [BCW-1:0] req_rdusedw_i,
    output logic [31:0]         resp_data_o,
    output logic                resp_valid_o,
    avmm_req_master_if.master   avm
);
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_HDR       = 4'd1,
        S_WAIT_FILL = 4'd2,
        S_WDATA     = 4'd3,
        S_WLATCH    = 4'd4,
        S_WR        = 4'd5,
        S_RESP_HDR  = 4'd6,
        S_RD        = 4'd7,
        S_RDATA     = 4'd8
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [31:0]    r_hdr, r_wdata, r_rd_data, w_rd_word_data;
    logic           r_rd_valid, r_run;
    logic [BCW-1:0] r_beat, w_len, w_beat_inc;
    logic [13:0]    w_len_fld;
    logic           w_last, w_tmo, w_tmo_hit, w_wr_done, w_rd_word;
    logic           w_rd_on, w_wr_on, w_acc;

    // Burst length is clamped so Avalon burstcount and response count agree.
    assign w_len_fld = r_hdr[29:16];
    always_comb begin
        w_len = BCW'(1);
        if (r_hdr[30]) begin
            if ({18'd0, w_len_fld} > 32'(MAX_BURST))
                w_len = BCW'(MAX_BURST);
            else
                w_len = BCW'(w_len_fld);
        end
    end

    assign w_beat_inc = r_beat + 1'b1;
    assign w_last     = (w_beat_inc == w_len);
    assign w_wr_done  = !avm.waitrequest || w_tmo || w_tmo_hit;
    assign w_rd_word  = (r_state == S_RDATA) && (avm.readdatavalid || w_tmo);

`ifdef AVMM_REQ_MASTER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] r_wdog;
    logic           r_tmo, w_stall;

    assign w_stall = (r_state == S_WR    && avm.waitrequest && !r_tmo) ||
                     (r_state == S_RD    && avm.waitrequest)            ||
                     (r_state == S_RDATA && !avm.readdatavalid && !r_tmo);
    assign w_tmo_hit = w_stall && (r_wdog == WDW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wdog <= '0;
            r_tmo  <= 1'b0;
        end else begin
            r_wdog <= (w_stall && !w_tmo_hit) ? r_wdog + 1'b1 : '0;
            if (r_state == S_IDLE)
                r_tmo <= 1'b0;
            else if (w_tmo_hit)
                r_tmo <= 1'b1;
        end
    end

    assign w_tmo          = r_tmo;
    assign w_rd_word_data = r_tmo ? 32'hDEAD_BEEF : avm.readdata;
`else
    assign w_tmo          = 1'b0;
    assign w_tmo_hit      = 1'b0;
    assign w_rd_word_data = avm.readdata;
`endif

    if (ADDR_W < 18 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("avmm_req_master: ADDR_W must be >= 18 and TIMEOUT_CYC >= 1");
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (r_run && !req_rdempty_i) w_state_nxt = S_HDR;
            S_HDR: begin
                if (req_q_i[30] && req_q_i[29:16] == 14'd0) w_state_nxt = S_RESP_HDR;
                else if (!req_q_i[31])                      w_state_nxt = S_RESP_HDR;
                else if (!req_q_i[30])                      w_state_nxt = S_WDATA;
                else                                        w_state_nxt = S_WAIT_FILL;
            end
            S_WAIT_FILL: if (req_rdusedw_i >= w_len) w_state_nxt = S_WDATA;
            S_WDATA:     w_state_nxt = S_WLATCH;
            S_WLATCH:    w_state_nxt = S_WR;
            S_WR:        if (w_wr_done) w_state_nxt = w_last ? S_RESP_HDR : S_WDATA;
            S_RESP_HDR:  w_state_nxt = (r_hdr[31] || w_len == '0) ? S_IDLE : S_RD;
            S_RD:        if (!avm.waitrequest || w_tmo_hit) w_state_nxt = S_RDATA;
            S_RDATA:     if (w_rd_word && w_last) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // r_run keeps the FIFO untouched until the first clock after reset release.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_run      <= 1'b0;
            r_hdr      <= '0;
            r_wdata    <= '0;
            r_beat     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_run      <= 1'b1;
            r_rd_valid <= w_rd_word;
            if (r_state == S_HDR) begin
                r_hdr  <= req_q_i;
                r_beat <= '0;
            end
            if (r_state == S_WLATCH)
                r_wdata <= req_q_i;
            if ((r_state == S_WR && w_wr_done) || w_rd_word)
                r_beat <= w_beat_inc;
            if (w_rd_word)
                r_rd_data <= w_rd_word_data;
        end
    end

    assign w_rd_on = (r_state == S_RD);
    assign w_wr_on = (r_state == S_WR) && !w_tmo;
    assign w_acc   = w_rd_on || w_wr_on;

    assign req_rdreq_o      = (r_state == S_IDLE && r_run && !req_rdempty_i) || (r_state == S_WDATA);
    assign avm.read         = w_rd_on;
    assign avm.write        = w_wr_on;
    assign avm.writedata    = r_wdata;
    assign avm.address      = w_acc ? ADDR_W'({r_hdr[15:0], 2'b00}) : '0;
    assign avm.byteenable   = w_acc ? (r_hdr[30] ? 4'hF : r_hdr[19:16]) : 4'h0;
    assign avm.burstcount   = w_acc ? w_len : '0;

    assign resp_valid_o = (r_state == S_RESP_HDR) || r_rd_valid;
    assign resp_data_o  = (r_state == S_RESP_HDR) ? r_hdr : (r_rd_valid ? r_rd_data : 32'd0);
endmodule
`default_nettype wire

// File: tb/tb_avmm_req_master.sv
`default_nettype none
// =====================================================================
// Module   : tb_avmm_req_master
// Purpose  : Directed self-checking bench for avmm_req_master.
// Revision : 1.0 - initial release
// =====================================================================
module tb_avmm_req_master;
    localparam int MAX_BURST   = 1024;
    localparam int ADDR_W      = 32;
    localparam int TIMEOUT_CYC = 16;
    localparam int BCW         = $clog2(MAX_BURST) + 1;

    logic           clk = 1'b0;
    logic           rstn;
    logic           req_rdreq;
    logic [31:0]    req_q = 32'd0;
    logic           req_rdempty;
    logic [BCW-1:0] req_rdusedw;
    logic [31:0]    resp_data;
    logic           resp_valid;

    always #5 clk = ~clk;

    avmm_req_master_if #(.ADDR_W(ADDR_W), .BCW(BCW)) avm ();

    avmm_req_master #(
        .MAX_BURST   (MAX_BURST),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .req_rdreq_o   (req_rdreq),
        .req_q_i       (req_q),
        .req_rdempty_i (req_rdempty),
        .req_rdusedw_i (req_rdusedw),
        .resp_data_o   (resp_data),
        .resp_valid_o  (resp_valid),
        .avm           (avm)
    );

    typedef struct packed {
        logic [31:0]    addr;
        logic [3:0]     be;
        logic [BCW-1:0] bc;
        logic [31:0]    data;
    } beat_t;

    logic [31:0] fifo[$];
    beat_t       wr_q[$];
    beat_t       rd_q[$];
    logic [31:0] resp_q[$];
    int          wr_cyc_q[$];
    int          rd_hi_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    assign req_rdempty = (fifo.size() == 0);
    assign req_rdusedw = BCW'(fifo.size());

    // Normal-mode FIFO: data appears the cycle after rdreq.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_rdreq && fifo.size() > 0)
            req_q <= fifo.pop_front();
    end

    always @(negedge clk) begin
        if (avm.write) wr_cyc_q.push_back(cyc);
        if (avm.read)  rd_hi_q.push_back(cyc);
        if (avm.write && !avm.waitrequest)
            wr_q.push_back('{avm.address, avm.byteenable, avm.burstcount, avm.writedata});
        if (avm.read && !avm.waitrequest)
            rd_q.push_back('{avm.address, avm.byteenable, avm.burstcount, 32'd0});
        if (resp_valid) resp_q.push_back(resp_data);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q.delete(); rd_q.delete(); resp_q.delete();
        wr_cyc_q.delete(); rd_hi_q.delete();
    endtask

    task automatic wait_resp(input string tag, input int n, input int budget);
        int b = budget;
        while (resp_q.size() < n && b > 0) begin
            tick(1);
            b--;
        end
        tick(4);
        chk({tag, " resp count"}, 64'(resp_q.size()), 64'(n));
    endtask

    task automatic wait_read(input int budget);
        int b = budget;
        while (!avm.read && b > 0) begin
            tick(1);
            b--;
        end
    endtask

    initial begin
        int fill_cyc;
        int b;
        rstn = 1'b0;
        avm.waitrequest = 1'b0;
        avm.readdata = 32'd0;
        avm.readdatavalid = 1'b0;
        tick(3);
        chk("reset rdreq/resp_valid/read/write",
            {60'd0, req_rdreq, resp_valid, avm.read, avm.write}, 64'd0);
        chk("reset addr/be/bc", {avm.address, avm.byteenable, 17'd0, avm.burstcount}, 64'd0);
        chk("reset data", {resp_data, avm.writedata}, 64'd0);
        rstn = 1'b1;
        tick(2);

        // WRITE NOBURST
        clear_logs();
        fifo.push_back(32'h800F_0010);
        fifo.push_back(32'h1234_5678);
        wait_resp("wr single", 1, 60);
        chk("wr single beats", 64'(wr_q.size()), 64'd1);
        chk("wr single beat", 64'(wr_q[0]), 64'({32'h40, 4'hF, BCW'(1), 32'h1234_5678}));
        chk("wr single hdr echo", 64'(resp_q[0]), 64'h800F_0010);

        // BURST with len 0: header echo only
        clear_logs();
        fifo.push_back(32'hC000_0050);
        wait_resp("len0", 1, 60);
        chk("len0 no write", 64'(wr_cyc_q.size()), 64'd0);
        chk("len0 hdr echo", 64'(resp_q[0]), 64'hC000_0050);

        // WRITE BURST len 4, slow fill
        clear_logs();
        fifo.push_back(32'hC004_0020);
        fill_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            tick(5);
            fifo.push_back(32'h1111_0000 + i);
            fill_cyc = cyc;
        end
        wait_resp("wr burst", 1, 100);
        chk("wr burst waits for fill",
            64'(wr_cyc_q.size() > 0 && wr_cyc_q[0] > fill_cyc), 64'd1);
        chk("wr burst beats", 64'(wr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wr burst beat%0d", i), 64'(wr_q[i]),
                64'({32'h80, 4'hF, BCW'(4), 32'h1111_0000 + i}));
        chk("wr burst hdr echo", 64'(resp_q[0]), 64'hC004_0020);

        // READ BURST len 8, 3 waitrequest cycles, gapped data
        clear_logs();
        avm.waitrequest = 1'b1;
        fifo.push_back(32'h4008_0100);
        wait_read(40);
        tick(1);
        avm.readdatavalid = 1'b1;            // stray data before RDATA
        avm.readdata = 32'hBAD0_BAD0;
        tick(1);
        avm.readdatavalid = 1'b0;
        tick(1);
        avm.waitrequest = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            avm.readdatavalid = 1'b1;
            avm.readdata = 32'hA5A5_0000 + i;
            tick(1);
            avm.readdatavalid = 1'b0;
            tick(i % 3);
        end
        wait_resp("rd burst", 9, 60);
        chk("rd burst read held", 64'(rd_hi_q.size()), 64'd4);
        chk("rd burst cmd", 64'(rd_q[0]), 64'({32'h400, 4'hF, BCW'(8), 32'd0}));
        chk("rd burst hdr echo", 64'(resp_q[0]), 64'h4008_0100);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rd burst word%0d", i), 64'(resp_q[i+1]), 64'(32'hA5A5_0000 + i));

        // READ NOBURST byteenable 3
        clear_logs();
        fifo.push_back(32'h0003_0200);
        wait_read(40);
        tick(1);
        avm.readdatavalid = 1'b1;
        avm.readdata = 32'h5EED_0001;
        tick(1);
        avm.readdatavalid = 1'b0;
        wait_resp("rd single", 2, 40);
        chk("rd single cmd", 64'(rd_q[0]), 64'({32'h800, 4'h3, BCW'(1), 32'd0}));
        chk("rd single hdr echo", 64'(resp_q[0]), 64'h0003_0200);
        chk("rd single word", 64'(resp_q[1]), 64'h5EED_0001);

        // Reset after beat 2 of 4; remaining FIFO words form a new request
        clear_logs();
        fifo.push_back(32'hC004_0040);
        fifo.push_back(32'h2222_0000);
        fifo.push_back(32'h2222_0001);
        fifo.push_back(32'h8005_0030);
        fifo.push_back(32'hCAFE_F00D);
        b = 80;
        while (wr_q.size() < 2 && b > 0) begin
            tick(1);
            b--;
        end
        chk("rst mid-burst beats before reset", 64'(wr_q.size()), 64'd2);
        #1 rstn = 1'b0;
        #1;
        chk("rst async rdreq/resp_valid/read/write",
            {60'd0, req_rdreq, resp_valid, avm.read, avm.write}, 64'd0);
        chk("rst async addr/be/bc", {avm.address, avm.byteenable, 17'd0, avm.burstcount}, 64'd0);
        chk("rst async data", {resp_data, avm.writedata}, 64'd0);
        tick(3);
        chk("rst no partial response", 64'(resp_q.size()), 64'd0);
        rstn = 1'b1;
        wait_resp("rst next hdr", 1, 60);
        chk("rst next hdr beats", 64'(wr_q.size()), 64'd3);
        chk("rst next hdr beat", 64'(wr_q[2]), 64'({32'hC0, 4'h5, BCW'(1), 32'hCAFE_F00D}));
        chk("rst next hdr echo", 64'(resp_q[0]), 64'h8005_0030);

`ifdef AVMM_REQ_MASTER_TIMEOUT_EN
        // Watchdog: read burst len 2 with waitrequest stuck high
        clear_logs();
        avm.waitrequest = 1'b1;
        fifo.push_back(32'h4002_0000);
        wait_resp("tmo", 3, 120);
        chk("tmo read cycles", 64'(rd_hi_q.size()), 64'(TIMEOUT_CYC));
        chk("tmo hdr echo", 64'(resp_q[0]), 64'h4002_0000);
        chk("tmo word0", 64'(resp_q[1]), 64'hDEAD_BEEF);
        chk("tmo word1", 64'(resp_q[2]), 64'hDEAD_BEEF);
        chk("tmo read released", {63'd0, avm.read}, 64'd0);
        avm.waitrequest = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end
endmodule
`default_nettype wire
